// File: rtl/dft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dft_pkg
// Brief    : Shared types and constants for the DFT dump collector.
// Revision : 1.0 - initial release
// ============================================================================
package dft_pkg;

  // Width of one scan-dump data word.
  localparam int DFT_WORD_W = 32;

  // Collector FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_ACK  = 2'd3
  } dft_state_e;

endpackage
`default_nettype wire

// File: rtl/dft_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dft_capture_fifo
// Brief    : Synchronous first-word-fall-through capture buffer. The head
//            word is presented combinationally; the parent decides when a
//            push is legal.
// Revision : 1.0 - initial release
// ============================================================================
module dft_capture_fifo
  import dft_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DFT_WORD_W-1:0]   din,
  output logic [DFT_WORD_W-1:0]   dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one wrap bit above the log2(DEPTH) address bits, so the
  // plain difference gives the fill level from 0 up to DEPTH.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DFT_WORD_W-1:0] mem_q [DEPTH];
  logic                  pop_ok;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (count == '0);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A read of an empty buffer is simply ignored.
  assign pop_ok = pop & ~empty;
  // Drive zero while empty so the head output is deterministic after reset.
  assign dout   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)   wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; clearing them empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/dft_dump_collector.sv
`default_nettype none
// ============================================================================
// Module   : dft_dump_collector
// Brief    : Host-side initiator/receiver for the DFT dump interface.
//            Requests a dump, captures strobed words into a FWFT buffer,
//            acknowledges the commit and reports length/overflow status.
// Revision : 1.0 - initial release
// ============================================================================
module dft_dump_collector
  import dft_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int EXP_WORDS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    dft_val_op,
  input  logic                    dft_op_ack,
  input  logic [DFT_WORD_W-1:0]   dft_out,
  input  logic                    dft_out_strobe,
  input  logic                    dft_op_commit,
  output logic                    dft_commit_ack,
  input  logic                    rd_en,
  output logic [DFT_WORD_W-1:0]   rd_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             word_cnt,
  output logic                    overflow,
  output logic                    len_err
);

  dft_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        val_op_q, val_op_d;
  logic        commit_ack_q, commit_ack_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        overflow_q, overflow_d;
  logic        len_err_q, len_err_d;

  logic        capt_strobe;
  logic        fifo_full;
  logic        fifo_push;

  // Words are only accepted while a dump is requested or in progress.
  assign capt_strobe = dft_out_strobe && ((state_q == ST_REQ) || (state_q == ST_CAPT));
  // A full buffer still accepts a word when a read frees a slot this cycle.
  assign fifo_push   = capt_strobe && (!fifo_full || rd_en);

  dft_capture_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (rd_en),
    .din   (dft_out),
    .dout  (rd_data),
    .count (count),
    .empty (empty),
    .full  (fifo_full)
  );

  // Next-state and registered-output logic for the dump handshake.
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    val_op_d     = val_op_q;
    commit_ack_d = commit_ack_q;
    word_cnt_d   = word_cnt_q;
    overflow_d   = overflow_q;
    len_err_d    = len_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_REQ;
          val_op_d   = 1'b1;
          word_cnt_d = '0;
          overflow_d = 1'b0;
          len_err_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (dft_op_ack) begin
          state_d  = ST_CAPT;
          val_op_d = 1'b0;
        end
      end
      ST_CAPT: begin
        if (dft_op_commit) begin
          state_d      = ST_ACK;
          commit_ack_d = 1'b1;
        end
      end
      ST_ACK: begin
        if (!dft_op_commit) begin
          state_d      = ST_IDLE;
          commit_ack_d = 1'b0;
          done_d       = 1'b1;
          len_err_d    = (word_cnt_q != 16'(EXP_WORDS));
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every captured strobe counts, even one that is dropped for lack of room.
    if (capt_strobe) begin
      if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
      if (fifo_full && !rd_en)    overflow_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any handshake in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      val_op_q     <= 1'b0;
      commit_ack_q <= 1'b0;
      word_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      val_op_q     <= val_op_d;
      commit_ack_q <= commit_ack_d;
      word_cnt_q   <= word_cnt_d;
      overflow_q   <= overflow_d;
      len_err_q    <= len_err_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign dft_val_op     = val_op_q;
  assign dft_commit_ack = commit_ack_q;
  assign word_cnt       = word_cnt_q;
  assign overflow       = overflow_q;
  assign len_err        = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dft_dump_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_dft_dump_collector
// Brief    : Self-checking bench. Two collectors share one responder: A is
//            DEPTH=32/EXP_WORDS=1, B is DEPTH=4/EXP_WORDS=3. Expected words
//            are queued per instance as they are strobed and compared on read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dft_dump_collector;

  localparam int DEPTH_A = 32;
  localparam int EXP_A   = 1;
  localparam int DEPTH_B = 4;
  localparam int EXP_B   = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dft_op_ack = 1'b0;
  logic [31:0] dft_out = '0;
  logic        dft_out_strobe = 1'b0;
  logic        dft_op_commit = 1'b0;
  logic        rd_en = 1'b0;

  logic        busy_a, done_a, val_op_a, commit_ack_a, empty_a, overflow_a, len_err_a;
  logic [31:0] rd_data_a;
  logic [5:0]  count_a;
  logic [15:0] word_cnt_a;

  logic        busy_b, done_b, val_op_b, commit_ack_b, empty_b, overflow_b, len_err_b;
  logic [31:0] rd_data_b;
  logic [2:0]  count_b;
  logic [15:0] word_cnt_b;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          dc0;
  int          exp_wc;
  bit          exp_ovf_b;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  dft_dump_collector #(.DEPTH(DEPTH_A), .EXP_WORDS(EXP_A)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .dft_val_op(val_op_a), .dft_op_ack(dft_op_ack), .dft_out(dft_out),
    .dft_out_strobe(dft_out_strobe), .dft_op_commit(dft_op_commit),
    .dft_commit_ack(commit_ack_a), .rd_en(rd_en), .rd_data(rd_data_a),
    .empty(empty_a), .count(count_a), .word_cnt(word_cnt_a),
    .overflow(overflow_a), .len_err(len_err_a)
  );

  dft_dump_collector #(.DEPTH(DEPTH_B), .EXP_WORDS(EXP_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .dft_val_op(val_op_b), .dft_op_ack(dft_op_ack), .dft_out(dft_out),
    .dft_out_strobe(dft_out_strobe), .dft_op_commit(dft_op_commit),
    .dft_commit_ack(commit_ack_b), .rd_en(rd_en), .rd_data(rd_data_b),
    .empty(empty_b), .count(count_b), .word_cnt(word_cnt_b),
    .overflow(overflow_b), .len_err(len_err_b)
  );

  // Count done pulses of instance B, sampled mid-cycle.
  always @(negedge clk) begin
    if (done_b === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a dump, let the responder wait one cycle, then acknowledge.
  task automatic begin_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_wc    = 0;
    exp_ovf_b = 1'b0;
    check_eq("val_op_after_start_b", 32'(val_op_b), 32'd1);
    check_eq("val_op_after_start_a", 32'(val_op_a), 32'd1);
    check_eq("busy_after_start", 32'(busy_b), 32'd1);
    check_eq("word_cnt_cleared", 32'(word_cnt_b), 32'd0);
    step();
    check_eq("val_op_held", 32'(val_op_b), 32'd1);
    dft_op_ack = 1'b1;
    step();
    dft_op_ack = 1'b0;
    check_eq("val_op_drop_after_ack", 32'(val_op_b), 32'd0);
  endtask

  // Strobe one word, optionally with a read and/or commit in the same cycle.
  task automatic strobe_word(input logic [31:0] w, input bit rd, input bit cm);
    dft_out        = w;
    dft_out_strobe = 1'b1;
    rd_en          = rd;
    dft_op_commit  = cm;
    if (rd) begin
      if (qa.size() > 0) begin
        check_eq("rd_data_a_same_cycle", rd_data_a, qa[0]);
        qa.delete(0);
      end
      if (qb.size() > 0) begin
        check_eq("rd_data_b_same_cycle", rd_data_b, qb[0]);
        qb.delete(0);
      end
    end
    if (qa.size() < DEPTH_A) qa.push_back(w);
    if (qb.size() < DEPTH_B) qb.push_back(w);
    else exp_ovf_b = 1'b1;
    exp_wc++;
    step();
    dft_out_strobe = 1'b0;
    rd_en          = 1'b0;
    dft_out        = '0;
    check_eq("word_cnt_inc", 32'(word_cnt_b), 32'(exp_wc));
  endtask

  // Commit handshake and done pulse.
  task automatic end_dump();
    dft_op_commit = 1'b1;
    step();
    check_eq("commit_ack_follows", 32'(commit_ack_b), 32'd1);
    check_eq("no_done_during_ack", 32'(done_b), 32'd0);
    dft_op_commit = 1'b0;
    step();
    check_eq("done_pulse_b", 32'(done_b), 32'd1);
    check_eq("done_pulse_a", 32'(done_a), 32'd1);
    check_eq("commit_ack_release", 32'(commit_ack_b), 32'd0);
    check_eq("busy_idle_a", 32'(busy_a), 32'd0);
    check_eq("overflow_b", 32'(overflow_b), 32'(exp_ovf_b));
    step();
    check_eq("done_one_cycle", 32'(done_b), 32'd0);
  endtask

  // Pop everything the model expects, comparing each head word.
  task automatic drain();
    rd_en = 1'b1;
    for (int i = 0; i < 40 && (qa.size() > 0 || qb.size() > 0); i++) begin
      if (qa.size() > 0) check_eq("rd_data_a", rd_data_a, qa[0]);
      if (qb.size() > 0) check_eq("rd_data_b", rd_data_b, qb[0]);
      step();
      if (qa.size() > 0) qa.delete(0);
      if (qb.size() > 0) qb.delete(0);
    end
    rd_en = 1'b0;
    check_eq("empty_after_drain_a", 32'(empty_a), 32'd1);
    check_eq("empty_after_drain_b", 32'(empty_b), 32'd1);
    check_eq("count_after_drain_b", 32'(count_b), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 reset = 1'b0;
    step();
    step();
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_val_op", 32'(val_op_a), 32'd0);
    check_eq("rst_commit_ack", 32'(commit_ack_a), 32'd0);
    check_eq("rst_empty", 32'(empty_a), 32'd1);
    check_eq("rst_count", 32'(count_a), 32'd0);
    check_eq("rst_rd_data", rd_data_a, 32'd0);
    check_eq("rst_word_cnt", 32'(word_cnt_a), 32'd0);
    check_eq("rst_overflow", 32'(overflow_a), 32'd0);
    check_eq("rst_len_err", 32'(len_err_a), 32'd0);
    reset = 1'b1;
    step();

    // Single-word dump
    begin_dump();
    strobe_word(32'hDEADBEEF, 1'b0, 1'b0);
    end_dump();
    check_eq("t1_rd_data_a", rd_data_a, 32'hDEADBEEF);
    check_eq("t1_count_a", 32'(count_a), 32'd1);
    check_eq("t1_word_cnt_a", 32'(word_cnt_a), 32'd1);
    check_eq("t1_len_err_a", 32'(len_err_a), 32'd0);
    check_eq("t1_len_err_b", 32'(len_err_b), 32'd1);
    drain();

    // Three words, the last on the commit-rise cycle
    begin_dump();
    strobe_word(32'h1, 1'b0, 1'b0);
    strobe_word(32'h2, 1'b0, 1'b0);
    strobe_word(32'h3, 1'b0, 1'b1);
    end_dump();
    check_eq("t2_count_b", 32'(count_b), 32'd3);
    check_eq("t2_word_cnt_b", 32'(word_cnt_b), 32'd3);
    check_eq("t2_len_err_b", 32'(len_err_b), 32'd0);
    check_eq("t2_len_err_a", 32'(len_err_a), 32'd1);
    drain();

    // Six words into a 4-deep buffer
    begin_dump();
    for (int i = 0; i < 6; i++) strobe_word(32'hA0 + 32'(i), 1'b0, 1'b0);
    end_dump();
    check_eq("t3_count_b", 32'(count_b), 32'd4);
    check_eq("t3_overflow_b", 32'(overflow_b), 32'd1);
    check_eq("t3_word_cnt_b", 32'(word_cnt_b), 32'd6);
    check_eq("t3_len_err_b", 32'(len_err_b), 32'd1);
    check_eq("t3_count_a", 32'(count_a), 32'd6);
    check_eq("t3_overflow_a", 32'(overflow_a), 32'd0);
    drain();

    // Full buffer with simultaneous read and strobe
    begin_dump();
    for (int i = 0; i < 4; i++) strobe_word(32'hB0 + 32'(i), 1'b0, 1'b0);
    check_eq("t4_full_count", 32'(count_b), 32'd4);
    strobe_word(32'hB4, 1'b1, 1'b0);
    check_eq("t4_count_unchanged", 32'(count_b), 32'd4);
    check_eq("t4_no_overflow", 32'(overflow_b), 32'd0);
    end_dump();
    drain();

    // start pulsed while capturing
    begin_dump();
    dc0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t5_val_op_unchanged", 32'(val_op_b), 32'd0);
    check_eq("t5_word_cnt_unchanged", 32'(word_cnt_b), 32'd0);
    check_eq("t5_busy", 32'(busy_b), 32'd1);
    strobe_word(32'hC0, 1'b0, 1'b0);
    strobe_word(32'hC1, 1'b0, 1'b0);
    strobe_word(32'hC2, 1'b0, 1'b1);
    end_dump();
    step();
    step();
    check_eq("t5_one_done", 32'(done_cnt - dc0), 32'd1);
    check_eq("t5_len_err_b", 32'(len_err_b), 32'd0);
    drain();

    // Reset in the middle of a dump
    begin_dump();
    strobe_word(32'hD0, 1'b0, 1'b0);
    strobe_word(32'hD1, 1'b0, 1'b0);
    check_eq("t6_count_before", 32'(count_b), 32'd2);
    dc0 = done_cnt;
    reset = 1'b0;
    #1;
    check_eq("t6_busy", 32'(busy_b), 32'd0);
    check_eq("t6_val_op", 32'(val_op_b), 32'd0);
    check_eq("t6_commit_ack", 32'(commit_ack_b), 32'd0);
    check_eq("t6_empty", 32'(empty_b), 32'd1);
    check_eq("t6_count", 32'(count_b), 32'd0);
    qa.delete();
    qb.delete();
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("t6_no_done", 32'(done_cnt - dc0), 32'd0);
    begin_dump();
    strobe_word(32'hE0, 1'b0, 1'b0);
    strobe_word(32'hE1, 1'b0, 1'b0);
    strobe_word(32'hE2, 1'b0, 1'b0);
    end_dump();
    check_eq("t6_len_err_b", 32'(len_err_b), 32'd0);
    check_eq("t6_count_after", 32'(count_b), 32'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
